// File: rtl/prbs_checker_axis_if.sv
// Stream bundle for the PRBS checker: received bit stream, parameter writes,
// and the error-count / status outputs.
//
// Handshake: none of these streams has a tready. A tvalid that is high during
// a rising clk edge transfers exactly one beat (one PRBS bit, one parameter
// write, or one checked-bit report); the sink can never stall the source, so
// every tvalid-high cycle is consumed.
interface prbs_checker_axis_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PRBS_tdata;
  logic                        S_AXIS_PRBS_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_PARAM_tdata;
  logic                        S_AXIS_PARAM_tvalid;
  logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_ERR_tdata;
  logic                        M_AXIS_ERR_tvalid;
  logic                        locked;
  logic                        bit_err;

  // Driver side: supplies bits and parameter writes, observes results.
  modport master (
    output S_AXIS_PRBS_tdata, S_AXIS_PRBS_tvalid,
    output S_AXIS_PARAM_tdata, S_AXIS_PARAM_tvalid,
    input  M_AXIS_ERR_tdata, M_AXIS_ERR_tvalid, locked, bit_err
  );

  // Checker side.
  modport slave (
    input  S_AXIS_PRBS_tdata, S_AXIS_PRBS_tvalid,
    input  S_AXIS_PARAM_tdata, S_AXIS_PARAM_tvalid,
    output M_AXIS_ERR_tdata, M_AXIS_ERR_tvalid, locked, bit_err
  );
endinterface

// File: rtl/prbs_checker_axis.sv
// PRBS checker: acquires lock on a PRBS7/9/15/23/31 bit stream, then runs a
// free-running reference, counts bit errors and drops lock when too many
// errors land in one evaluation window.
module prbs_checker_axis #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOCK_COUNT       = 64,
  parameter int LOSS_WINDOW      = 64,
  parameter int LOSS_THRESH      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  prbs_checker_axis_if.slave axis,
  output logic               dbg_state
);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int EW = $clog2(LOSS_THRESH + 1);
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(LOSS_WINDOW - 1);
  localparam logic [EW-1:0] THRESH    = EW'(LOSS_THRESH);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t                      state;
  logic [2:0]                  sel;
  logic [30:0]                 hist;       // hist[k-1] holds the bit k strobes ago
  logic [4:0]                  fill;
  logic [MW-1:0]               match_cnt;
  logic [WW-1:0]               win_cnt;
  logic [EW-1:0]               win_err;
  logic [AXIS_TDATA_WIDTH-1:0] err_cnt;
  logic                        locked_r;
  logic                        bit_err_r;
  logic                        err_tvalid_r;

  logic [4:0]  tap_n;
  logic [4:0]  tap_t;
  logic        sel_valid;
  logic [30:0] hist_mask;
  logic        hist_zero;
  logic        pred;
  logic        rx_bit;
  logic        mismatch;
  logic [EW-1:0] tally_next;
  logic [2:0]  param_sel;
  logic        param_clr;
  logic        unused_tdata;

  assign rx_bit    = axis.S_AXIS_PRBS_tdata[0];
  assign param_sel = axis.S_AXIS_PARAM_tdata[2:0];
  assign param_clr = axis.S_AXIS_PARAM_tdata[8];
  assign unused_tdata = ^{axis.S_AXIS_PRBS_tdata[AXIS_TDATA_WIDTH-1:1],
                          axis.S_AXIS_PARAM_tdata[AXIS_TDATA_WIDTH-1:9],
                          axis.S_AXIS_PARAM_tdata[7:3]};

  // Decode the polynomial select into recurrence taps and derive the prediction.
  always_comb begin
    tap_n     = 5'd7;
    tap_t     = 5'd6;
    sel_valid = 1'b1;
    case (sel)
      3'd0: begin tap_n = 5'd7;  tap_t = 5'd6;  end
      3'd1: begin tap_n = 5'd9;  tap_t = 5'd5;  end
      3'd2: begin tap_n = 5'd15; tap_t = 5'd14; end
      3'd3: begin tap_n = 5'd23; tap_t = 5'd18; end
      3'd4: begin tap_n = 5'd31; tap_t = 5'd28; end
      default: sel_valid = 1'b0;
    endcase
    hist_mask  = 31'h7fff_ffff >> (5'd31 - tap_n);
    hist_zero  = ((hist & hist_mask) == 31'd0);
    pred       = hist[tap_n - 5'd1] ^ hist[tap_t - 5'd1];
    mismatch   = rx_bit ^ pred;
    tally_next = win_err + EW'(mismatch);
  end

  // SEARCH/LOCKED state machine with parameter writes taking priority over bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEARCH;
      sel          <= 3'd0;
      hist         <= '0;
      fill         <= '0;
      match_cnt    <= '0;
      win_cnt      <= '0;
      win_err      <= '0;
      err_cnt      <= '0;
      locked_r     <= 1'b0;
      bit_err_r    <= 1'b0;
      err_tvalid_r <= 1'b0;
    end else begin
      bit_err_r    <= 1'b0;
      err_tvalid_r <= 1'b0;
      if (axis.S_AXIS_PARAM_tvalid) begin
        // A concurrent bit strobe is dropped so the new setting starts clean.
        if (param_sel != sel) begin
          sel       <= param_sel;
          state     <= SEARCH;
          locked_r  <= 1'b0;
          hist      <= '0;
          fill      <= '0;
          match_cnt <= '0;
          win_cnt   <= '0;
          win_err   <= '0;
        end
        if (param_clr) err_cnt <= '0;
      end else if (axis.S_AXIS_PRBS_tvalid && sel_valid) begin
        case (state)
          SEARCH: begin
            hist <= {hist[29:0], rx_bit};
            if (fill != tap_n) begin
              fill <= fill + 5'd1;
            end else if (mismatch || hist_zero) begin
              match_cnt <= '0;
            end else if (match_cnt == LOCK_LAST) begin
              state     <= LOCKED;
              locked_r  <= 1'b1;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end
          LOCKED: begin
            err_tvalid_r <= 1'b1;
            bit_err_r    <= mismatch;
            if (mismatch && (err_cnt != '1)) err_cnt <= err_cnt + AXIS_TDATA_WIDTH'(1);
            if (tally_next == THRESH) begin
              state     <= SEARCH;
              locked_r  <= 1'b0;
              hist      <= '0;
              fill      <= '0;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end else begin
              // The reference free-runs on its own prediction once locked.
              hist <= {hist[29:0], pred};
              if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
              end else begin
                win_cnt <= win_cnt + WW'(1);
                win_err <= tally_next;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign axis.M_AXIS_ERR_tdata  = err_cnt;
  assign axis.M_AXIS_ERR_tvalid = err_tvalid_r;
  assign axis.locked            = locked_r;
  assign axis.bit_err           = bit_err_r;
  assign dbg_state              = state;
endmodule

// File: tb/tb_prbs_checker_axis.sv
// Directed bench for prbs_checker_axis: PRBS generator for stimulus, an
// expected queue of {bit_err, error count} per checked bit, and a monitor
// that pops and compares on every M_AXIS_ERR_tvalid.
module tb_prbs_checker_axis;
  localparam int W  = 32;
  localparam int EW = W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;

  always #5 clk = ~clk;

  prbs_checker_axis_if #(.AXIS_TDATA_WIDTH(W)) bus ();

  prbs_checker_axis #(
    .AXIS_TDATA_WIDTH(W),
    .LOCK_COUNT(64),
    .LOSS_WINDOW(64),
    .LOSS_THRESH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .axis(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int n_checks = 0;
  int n_fail = 0;
  int bit_err_pulses = 0;
  int tvalid_pulses = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic e, input int c);
    exp_q.push_back({e, W'(c)});
  endtask

  // Monitor: every reported bit must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.bit_err === 1'b1) bit_err_pulses++;
      if (bus.M_AXIS_ERR_tvalid === 1'b1) begin
        tvalid_pulses++;
        if (exp_q.size() == 0) begin
          check1("err_tvalid_unexpected", bus.M_AXIS_ERR_tvalid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          checkw("err_count", bus.M_AXIS_ERR_tdata, mon_e[W-1:0]);
          check1("bit_err", bus.bit_err, mon_e[W]);
        end
      end
    end
  end

  // ---------------- PRBS generator ----------------
  logic [30:0] g;
  logic [4:0]  gn_i;
  logic [4:0]  gt_i;

  task automatic gen_seed(input int n, input int t);
    g    = 31'h1;
    gn_i = 5'(n - 1);
    gt_i = 5'(t - 1);
  endtask

  task automatic gen_next(output logic b);
    b = g[gn_i] ^ g[gt_i];
    g = {g[29:0], b};
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.S_AXIS_PRBS_tdata    = $urandom();
    bus.S_AXIS_PRBS_tdata[0] = b;
    bus.S_AXIS_PRBS_tvalid   = 1'b1;
    @(negedge clk);
    bus.S_AXIS_PRBS_tvalid   = 1'b0;
  endtask

  task automatic param_write(input logic [2:0] s, input logic clr,
                             input logic with_bit, input logic b);
    @(negedge clk);
    bus.S_AXIS_PARAM_tdata      = '0;
    bus.S_AXIS_PARAM_tdata[2:0] = s;
    bus.S_AXIS_PARAM_tdata[8]   = clr;
    bus.S_AXIS_PARAM_tvalid     = 1'b1;
    if (with_bit) begin
      bus.S_AXIS_PRBS_tdata  = W'(b);
      bus.S_AXIS_PRBS_tvalid = 1'b1;
    end
    @(negedge clk);
    bus.S_AXIS_PARAM_tvalid = 1'b0;
    bus.S_AXIS_PRBS_tvalid  = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Acquire lock from a fresh seed; checks locked just before and at lock.
  task automatic acquire(input string name, input int n, input int t);
    logic b;
    gen_seed(n, t);
    for (int i = 0; i < n + 64; i++) begin
      gen_next(b);
      send_bit(b);
      if (i == n + 62) check1({name, "_unlocked_before"}, bus.locked, 1'b0);
      if (i == n + 63) check1({name, "_locked_at"}, bus.locked, 1'b1);
    end
  endtask

  // ---------------- stimulus ----------------
  logic b;
  logic inv;
  int   exp_cnt;
  int   tv0;
  logic seen_lock;

  initial begin
    rst_n = 1'b0;
    bus.S_AXIS_PRBS_tdata   = '0;
    bus.S_AXIS_PRBS_tvalid  = 1'b0;
    bus.S_AXIS_PARAM_tdata  = '0;
    bus.S_AXIS_PARAM_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check1("rst_locked", bus.locked, 1'b0);
    check1("rst_bit_err", bus.bit_err, 1'b0);
    check1("rst_err_tvalid", bus.M_AXIS_ERR_tvalid, 1'b0);
    checkw("rst_err_count", bus.M_AXIS_ERR_tdata, '0);
    check1("rst_state", dbg_state, 1'b0);
    rst_n = 1'b1;

    // PRBS7 clean stream, 10000 strobes in total, default sel 0.
    gen_seed(7, 6);
    for (int i = 0; i < 10000; i++) begin
      gen_next(b);
      if (i >= 71) push(1'b0, 0);
      send_bit(b);
      if (i == 69) check1("prbs7_unlocked_70", bus.locked, 1'b0);
      if (i == 70) check1("prbs7_locked_71", bus.locked, 1'b1);
    end
    settle();
    checkw("prbs7_err_count", bus.M_AXIS_ERR_tdata, '0);
    check1("prbs7_still_locked", bus.locked, 1'b1);
    checki("prbs7_queue_drained", exp_q.size(), 0);

    // PRBS15 with three isolated inverted bits.
    param_write(3'd2, 1'b1, 1'b0, 1'b0);
    check1("sel2_drops_lock", bus.locked, 1'b0);
    checkw("sel2_clears_count", bus.M_AXIS_ERR_tdata, '0);
    acquire("prbs15", 15, 14);
    bit_err_pulses = 0;
    exp_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      gen_next(b);
      inv = (i == 20) || (i == 80) || (i == 150);
      if (inv) exp_cnt++;
      push(inv, exp_cnt);
      send_bit(b ^ inv);
    end
    settle();
    checki("prbs15_bit_err_pulses", bit_err_pulses, 3);
    checkw("prbs15_err_count", bus.M_AXIS_ERR_tdata, 32'd3);
    check1("prbs15_stays_locked", bus.locked, 1'b1);

    // PRBS31: eight errors inside one window force loss of lock.
    param_write(3'd4, 1'b1, 1'b0, 1'b0);
    acquire("prbs31", 31, 28);
    exp_cnt = 0;
    for (int j = 0; j < 16; j++) begin
      gen_next(b);
      inv = j[0];
      if (inv) exp_cnt++;
      push(inv, exp_cnt);
      send_bit(b ^ inv);
      if (j == 13) check1("prbs31_locked_at_7_errors", bus.locked, 1'b1);
    end
    check1("prbs31_lost_lock", bus.locked, 1'b0);
    check1("prbs31_state_search", dbg_state, 1'b0);
    checkw("prbs31_err_count_8", bus.M_AXIS_ERR_tdata, 32'd8);
    for (int k = 0; k < 95; k++) begin
      gen_next(b);
      send_bit(b);
      if (k == 93) check1("prbs31_relock_before", bus.locked, 1'b0);
      if (k == 94) check1("prbs31_relock_at", bus.locked, 1'b1);
    end
    checkw("prbs31_count_kept", bus.M_AXIS_ERR_tdata, 32'd8);

    // Param write concurrent with a strobe: strobe discarded, count cleared.
    param_write(3'd2, 1'b1, 1'b1, 1'b1);
    check1("concurrent_state_search", dbg_state, 1'b0);
    check1("concurrent_unlocked", bus.locked, 1'b0);
    checkw("concurrent_count_cleared", bus.M_AXIS_ERR_tdata, '0);
    acquire("concurrent_prbs15", 15, 14);
    for (int i = 0; i < 10; i++) begin
      gen_next(b);
      inv = (i == 4);
      push(inv, (i >= 4) ? 1 : 0);
      send_bit(b ^ inv);
    end
    settle();
    checkw("concurrent_one_error", bus.M_AXIS_ERR_tdata, 32'd1);

    // Invalid select: strobes ignored, error count untouched.
    param_write(3'd6, 1'b0, 1'b0, 1'b0);
    tv0 = tvalid_pulses;
    for (int i = 0; i < 150; i++) send_bit(1'($urandom_range(0, 1)));
    settle();
    check1("sel6_unlocked", bus.locked, 1'b0);
    check1("sel6_state_search", dbg_state, 1'b0);
    checkw("sel6_count_kept", bus.M_AXIS_ERR_tdata, 32'd1);
    checki("sel6_no_reports", tvalid_pulses - tv0, 0);

    // All-zero input on PRBS9 must never lock.
    param_write(3'd1, 1'b1, 1'b0, 1'b0);
    tv0 = tvalid_pulses;
    seen_lock = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send_bit(1'b0);
      if (bus.locked === 1'b1) seen_lock = 1'b1;
    end
    settle();
    check1("allzero_never_locked", seen_lock, 1'b0);
    checki("allzero_no_reports", tvalid_pulses - tv0, 0);
    checkw("allzero_count_zero", bus.M_AXIS_ERR_tdata, '0);

    // Reset while locked on PRBS7 with a nonzero count.
    param_write(3'd0, 1'b1, 1'b0, 1'b0);
    acquire("prbs7_pre_reset", 7, 6);
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      gen_next(b);
      inv = (i == 2) || (i == 6);
      if (inv) exp_cnt++;
      push(inv, exp_cnt);
      send_bit(b ^ inv);
    end
    settle();
    checkw("pre_reset_count", bus.M_AXIS_ERR_tdata, 32'd2);
    checki("pre_reset_queue_drained", exp_q.size(), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("async_rst_locked", bus.locked, 1'b0);
    checkw("async_rst_count", bus.M_AXIS_ERR_tdata, '0);
    check1("async_rst_state", dbg_state, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    acquire("prbs7_reacquire", 7, 6);

    settle();
    checki("final_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prbs_checker_axis.md
PRBS_CHECKER_AXIS -- requirements
Module: prbs_checker_axis

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, width of all AXIS tdata ports.
REQ-002 SHALL have parameter LOCK_COUNT, default 64, consecutive correct bits required to lock.
REQ-003 SHALL have parameter LOSS_WINDOW, default 64, bit window for loss-of-lock evaluation.
REQ-004 SHALL have parameter LOSS_THRESH, default 8, errors within one window that force loss of lock.
REQ-005 SHALL have ports: clk in 1 (sole clock); rst_n in 1 (asynchronous, active-low reset).
REQ-006 SHALL have ports: S_AXIS_PRBS_tdata in AXIS_TDATA_WIDTH (bit 0 = received PRBS bit); S_AXIS_PRBS_tvalid in 1 (one-cycle bit strobe, one bit per high cycle).
REQ-007 SHALL have ports: S_AXIS_PARAM_tdata in AXIS_TDATA_WIDTH ([2:0] polynomial select, [8] counter clear); S_AXIS_PARAM_tvalid in 1 (write strobe).
REQ-008 SHALL have ports: M_AXIS_ERR_tdata out AXIS_TDATA_WIDTH (error count); M_AXIS_ERR_tvalid out 1 (pulse per checked bit); locked out 1; bit_err out 1 (error pulse).

Function
REQ-009 SHALL define sel 0..4 as PRBS7/9/15/23/31 by b[n] = b[n-N] ^ b[n-T] with (N,T) = (7,6), (9,5), (15,14), (23,18), (31,28).
REQ-010 SHALL treat sel 5..7 as invalid: stay in SEARCH, ignore bit strobes, leave all counters unchanged.
REQ-011 SHALL use a 31-bit history register of past bits plus a fill counter; predicted bit = history tap N xor history tap T.
REQ-012 SHALL implement a two-state FSM, SEARCH and LOCKED.
REQ-013 SEARCH: each strobe shifts the received bit into history; once the fill counter reaches N, compare prediction with the received bit.
REQ-014 SEARCH: a match increments the consecutive-match counter; a mismatch, or an all-zero history, clears it.
REQ-015 SEARCH -> LOCKED on the strobe that brings the consecutive-match counter to LOCK_COUNT; locked asserts the next cycle.
REQ-016 LOCKED: history shifts in the predicted bit (free-running reference), never the received bit.
REQ-017 LOCKED: a received bit differing from the prediction is an error; bit_err pulses high for exactly one cycle, one cycle after the strobe.
REQ-018 LOCKED: the error counter (M_AXIS_ERR_tdata) increments by 1 per error and saturates at all-ones.
REQ-019 LOCKED: M_AXIS_ERR_tvalid pulses one cycle after every checked strobe; it stays low in SEARCH.
REQ-020 SHALL count checked bits in LOCKED in windows of LOSS_WINDOW; window error tally resets at each window boundary.
REQ-021 LOCKED -> SEARCH when the window tally reaches LOSS_THRESH: clear history, fill counter and match counter; deassert locked next cycle; keep the error counter.
REQ-022 Param write with a sel different from current: load sel, enter SEARCH, clear history, fill and match counters.
REQ-023 Param write with bit 8 set: clear the error counter.
REQ-024 Param write and bit strobe in the same cycle: apply the param write; discard the bit (no compare, no count, no pulse).
REQ-025 Param write with unchanged sel and bit 8 clear: no effect.

Reset
REQ-026 rst_n low SHALL asynchronously force: state SEARCH, sel 0, history 0, fill/match/window counters 0, error counter 0, locked 0, bit_err 0, M_AXIS_ERR_tvalid 0.
REQ-027 Reset mid-lock SHALL drop locked immediately; after release, lock requires a full reacquisition (N + LOCK_COUNT strobes).

Verification
REQ-028 sel=0, error-free PRBS7 stream with seed 7'h01 -> locked high after 7+64 strobes; error count stays 0 over 10000 bits.
REQ-029 Locked on PRBS15, invert 3 isolated bits -> exactly 3 bit_err pulses; M_AXIS_ERR_tdata = 3; locked stays high.
REQ-030 Locked on PRBS31, inject 8 errors within one 64-bit window -> locked low; error count 8; relock after 31+64 clean strobes.
REQ-031 All-zero input with sel=1 -> never locks; M_AXIS_ERR_tvalid never asserts.
REQ-032 Param write sel=2 with bit 8 set, concurrent with a strobe -> state SEARCH, count 0, strobe discarded; sel=6 -> strobes ignored.
REQ-033 rst_n pulsed low while locked -> locked and count 0 in the same cycle; reacquisition takes N+64 strobes.
